// File: rtl/div_pkg.sv
// Shared constants for the sequential restoring divider: FSM encoding and default width.
package div_pkg;
  localparam int         DIV_WIDTH_DEFAULT = 16;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/div_sub_stage.sv
// Combinational trial subtract a - b as a + ~b + 1 on a flattened carry-lookahead network.
module div_sub_stage #(
  parameter int W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);
  logic [W-1:0] bn, g, p;
  logic [W:0]   c;
  logic         term, acc;

  assign bn = ~b;
  assign g  = a & bn;
  assign p  = a ^ bn;

  // Each carry is a sum of generate terms gated by the propagate run above them;
  // a fully propagated run picks up the carry-in of 1.
  always_comb begin
    c    = '0;
    c[0] = 1'b1;
    term = 1'b1;
    acc  = 1'b0;
    for (int i = 0; i < W; i++) begin
      term = 1'b1;
      acc  = 1'b0;
      for (int j = i; j >= 0; j--) begin
        acc  = acc | (term & g[j]);
        term = term & p[j];
      end
      c[i+1] = acc | term;
    end
  end

  assign diff   = p ^ c[W-1:0];
  assign borrow = ~c[W];
endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one trial subtraction per clock, start/done handshake.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter  int WIDTH = DIV_WIDTH_DEFAULT,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d, d_q, d_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   trial_a, trial_b, trial_diff, next_r;
  logic [WIDTH-1:0] next_q;
  logic             trial_borrow;

  // Shift the next dividend bit into the partial remainder, then try to subtract D.
  assign trial_a = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign trial_b = {1'b0, d_q};

  div_sub_stage #(.W(WIDTH + 1)) u_sub (
    .a      (trial_a),
    .b      (trial_b),
    .diff   (trial_diff),
    .borrow (trial_borrow)
  );

  assign next_r = trial_borrow ? trial_a : trial_diff;
  assign next_q = {q_q[WIDTH-2:0], ~trial_borrow};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          r_d     = '0;
          q_d     = dividend;
          d_d     = divisor;
          cnt_d   = '0;
          dz_d    = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (d_q == '0) begin
          // Q still holds the untouched dividend, which is the remainder by convention.
          quo_d   = '1;
          rem_d   = q_q;
          dz_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          r_d   = next_r;
          q_d   = next_q;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            quo_d   = next_q;
            rem_d   = next_r[WIDTH-1:0];
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and random checks of seq_restoring_divider against plain / and % arithmetic.
module tb_seq_restoring_divider;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the accept edge with operands scrambled.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  // Waits (bounded) for done, checks latency in edges and results against arithmetic.
  task automatic wait_done(input string tag, input int exp_edges,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    int          n = 0;
    logic [31:0] eq, er, ez;
    if (b == '0) begin
      eq = 32'h0000_FFFF; er = 32'(a); ez = 1;
    end else begin
      eq = 32'(a) / 32'(b); er = 32'(a) % 32'(b); ez = 0;
    end
    while (!done && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_edges));
    chk({tag, "_q"}, 32'(quotient), eq);
    chk({tag, "_r"}, 32'(remainder), er);
    chk({tag, "_dz"}, 32'(div_by_zero), ez);
    if (b != '0) begin
      chk({tag, "_id"}, 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      chk({tag, "_rlt"}, 32'(remainder < b), 32'd1);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_q"}, 32'(quotient), 0);
    chk({tag, "_r"}, 32'(remainder), 0);
    chk({tag, "_dz"}, 32'(div_by_zero), 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bit           saw_done;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("rst");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1197 / 432
    accept(16'd1197, 16'd432);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_nodone", 32'(done), 0);
    wait_done("t1", W, 16'd1197, 16'd432);
    @(posedge clk);
    #1;
    chk("t1_pulse", 32'(done), 0);
    chk("t1_hold_q", 32'(quotient), 2);

    // All-ones boundaries
    accept(16'hFFFF, 16'd1);
    wait_done("t2a", W, 16'hFFFF, 16'd1);
    @(posedge clk); #1;
    accept(16'hFFFE, 16'hFFFF);
    wait_done("t2b", W, 16'hFFFE, 16'hFFFF);
    @(posedge clk); #1;
    accept(16'hFFFF, 16'hFFFF);
    wait_done("t2c", W, 16'hFFFF, 16'hFFFF);
    @(posedge clk); #1;

    // Divide by zero, then a normal op clears the flag
    accept(16'd1234, 16'd0);
    wait_done("t3a", 1, 16'd1234, 16'd0);
    @(posedge clk); #1;
    accept(16'd10, 16'd3);
    wait_done("t3b", W, 16'd10, 16'd3);
    @(posedge clk); #1;

    // start while busy is ignored; start in DONE cycle is accepted
    accept(16'd100, 16'd7);
    repeat (4) begin @(posedge clk); #1; end
    dividend = 16'd9; divisor = 16'd9; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("t4a", W - 5, 16'd100, 16'd7);
    accept(16'd9, 16'd9);
    wait_done("t4b", W, 16'd9, 16'd9);
    @(posedge clk); #1;

    // Reset mid-run aborts with no done pulse
    accept(16'd200, 16'd3);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check_idle_zero("t5_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("t5_nodone", 32'(saw_done), 0);
    accept(16'd50, 16'd5);
    wait_done("t5b", W, 16'd50, 16'd5);
    @(posedge clk); #1;

    // Random sweep with a mix of divisor ranges, alternating back-to-back accepts
    for (int i = 0; i < 2000; i++) begin
      ra = W'($urandom);
      case (i % 4)
        0: rb = W'($urandom);
        1: rb = W'($urandom_range(15, 1));
        2: rb = W'($urandom_range(255, 1));
        default: rb = ra + W'($urandom_range(3, 0));
      endcase
      if (i % 97 == 0) rb = '0;
      accept(ra, rb);
      wait_done("rnd", (rb == '0) ? 1 : W, ra, rb);
      if (i % 2 == 1) begin
        @(posedge clk);
        #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
